// File: rtl/xentry_pkg.sv
// xentry_pkg: shared memory-operation and data-cache controller state types.
package xentry_pkg;

    typedef enum logic {
        LOAD  = 1'b0,
        STORE = 1'b1
    } memory_operation_e;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WRITEBACK = 2'd1,
        FILL      = 2'd2,
        INSTALL   = 2'd3
    } dcache_state_e;

endpackage

// File: rtl/sat_counter.sv
// sat_counter: up-counter that sticks at all-ones instead of wrapping.
module sat_counter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    logic [WIDTH-1:0] count_q, count_d;

    always_comb count_d = (inc && !(&count_q)) ? count_q + WIDTH'(1) : count_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) count_q <= '0;
        else        count_q <= count_d;
    end

    assign count = count_q;

endmodule

// File: rtl/dcache_controller.sv
// dcache_controller: blocking data-cache miss FSM driving writeback/fill bursts to L2,
// with saturating hit/miss counters.
module dcache_controller
    import xentry_pkg::*;
#(
    parameter int PERF_CNT_WIDTH = 32,
    parameter int WORDS_PER_LINE = 8
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      req_valid,
    input  memory_operation_e         req_type,
    output logic                      req_fulfilled,
    input  logic                      hit,
    input  logic                      clean_miss,
    input  logic                      dirty_miss,
    input  logic                      counter_done,
    output logic                      flush_mode,
    output logic                      load_mode,
    output logic                      clear_selected_dirty_bit,
    output logic                      clear_selected_valid_bit,
    output logic                      finish_new_line_install,
    output logic                      set_new_l2_block_address,
    output logic                      reset_counter,
    output logic                      decrement_counter,
    output logic                      l2_req_valid,
    output memory_operation_e         l2_req_op,
    input  logic                      l2_req_fulfilled,
    output logic [PERF_CNT_WIDTH-1:0] hit_count,
    output logic [PERF_CNT_WIDTH-1:0] miss_count
);

    // Burst length is owned by the datapath counter; stores are written by the datapath on hit.
    localparam int unused_words_per_line = WORDS_PER_LINE;
    logic unused_req_type;
    assign unused_req_type = req_type == STORE;

    dcache_state_e state_q, state_d;
    logic          missed_q, missed_d;
    logic          miss_start;

    always_comb begin
        state_d                  = state_q;
        req_fulfilled            = 1'b0;
        flush_mode               = 1'b0;
        load_mode                = 1'b0;
        clear_selected_dirty_bit = 1'b0;
        clear_selected_valid_bit = 1'b0;
        finish_new_line_install  = 1'b0;
        set_new_l2_block_address = 1'b0;
        reset_counter            = 1'b0;
        decrement_counter        = 1'b0;
        l2_req_valid             = 1'b0;
        l2_req_op                = LOAD;
        // Outputs are gated by reset so nothing reaches the datapath while it is held.
        if (reset) begin
            case (state_q)
                IDLE: if (req_valid) begin
                    req_fulfilled            = hit;
                    set_new_l2_block_address = !hit && (dirty_miss || clean_miss);
                    reset_counter            = set_new_l2_block_address;
                    state_d = hit ? IDLE : dirty_miss ? WRITEBACK : clean_miss ? FILL : IDLE;
                end
                WRITEBACK: begin
                    flush_mode               = 1'b1;
                    l2_req_valid             = 1'b1;
                    l2_req_op                = STORE;
                    decrement_counter        = l2_req_fulfilled && !counter_done;
                    clear_selected_dirty_bit = l2_req_fulfilled && counter_done;
                    clear_selected_valid_bit = l2_req_fulfilled && counter_done;
                    state_d = (l2_req_fulfilled && counter_done) ? IDLE : WRITEBACK;
                end
                FILL: begin
                    load_mode         = 1'b1;
                    l2_req_valid      = 1'b1;
                    decrement_counter = l2_req_fulfilled;
                    state_d = (l2_req_fulfilled && counter_done) ? INSTALL : FILL;
                end
                default: begin
                    finish_new_line_install  = 1'b1;
                    clear_selected_dirty_bit = 1'b1;
                    state_d                  = IDLE;
                end
            endcase
        end
        miss_start = state_q == IDLE && state_d != IDLE;
        missed_d   = miss_start ? 1'b1 : req_fulfilled ? 1'b0 : missed_q;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            missed_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            missed_q <= missed_d;
        end
    end

    sat_counter #(.WIDTH(PERF_CNT_WIDTH)) u_hit_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (req_fulfilled && !missed_q),
        .count (hit_count)
    );

    sat_counter #(.WIDTH(PERF_CNT_WIDTH)) u_miss_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (miss_start && !missed_q),
        .count (miss_count)
    );

endmodule

// File: tb/tb_dcache_controller.sv
// tb_dcache_controller: randomized requests against a line/burst reference model with a scoreboard monitor.
module tb_dcache_controller;
    import xentry_pkg::*;

    localparam int WPL = 8;
    localparam int L_CLEAN = 0, L_DIRTY = 1, L_HIT = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset, req_valid, l2_req_fulfilled;
    memory_operation_e req_type;
    logic hit, clean_miss, dirty_miss, counter_done;
    logic req_fulfilled, flush_mode, load_mode, clr_dirty, clr_valid, install, set_addr, rst_cnt, dec_cnt, l2_req_valid;
    memory_operation_e l2_req_op;
    logic [31:0] hit_count, miss_count;
    logic s_ful, s_flush, s_load, s_cd, s_cv, s_inst, s_set, s_rc, s_dec, s_l2v;
    memory_operation_e s_op;
    logic [1:0] s_hit_count, s_miss_count;

    int lstate = L_CLEAN, cnt = 0;
    assign hit          = lstate == L_HIT;
    assign clean_miss   = lstate == L_CLEAN;
    assign dirty_miss   = lstate == L_DIRTY;
    assign counter_done = cnt == 0;

    dcache_controller #(.PERF_CNT_WIDTH(32), .WORDS_PER_LINE(WPL)) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_type(req_type), .req_fulfilled(req_fulfilled),
        .hit(hit), .clean_miss(clean_miss), .dirty_miss(dirty_miss), .counter_done(counter_done),
        .flush_mode(flush_mode), .load_mode(load_mode), .clear_selected_dirty_bit(clr_dirty),
        .clear_selected_valid_bit(clr_valid), .finish_new_line_install(install),
        .set_new_l2_block_address(set_addr), .reset_counter(rst_cnt), .decrement_counter(dec_cnt),
        .l2_req_valid(l2_req_valid), .l2_req_op(l2_req_op), .l2_req_fulfilled(l2_req_fulfilled),
        .hit_count(hit_count), .miss_count(miss_count)
    );

    dcache_controller #(.PERF_CNT_WIDTH(2), .WORDS_PER_LINE(WPL)) dut_s (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_type(req_type), .req_fulfilled(s_ful),
        .hit(hit), .clean_miss(clean_miss), .dirty_miss(dirty_miss), .counter_done(counter_done),
        .flush_mode(s_flush), .load_mode(s_load), .clear_selected_dirty_bit(s_cd),
        .clear_selected_valid_bit(s_cv), .finish_new_line_install(s_inst),
        .set_new_l2_block_address(s_set), .reset_counter(s_rc), .decrement_counter(s_dec),
        .l2_req_valid(s_l2v), .l2_req_op(s_op), .l2_req_fulfilled(l2_req_fulfilled),
        .hit_count(s_hit_count), .miss_count(s_miss_count)
    );

    typedef struct {
        int     stores;
        int     loads;
        int     installs;
        longint hits_before;
        longint misses_after;
    } exp_t;

    exp_t   q[$];
    int     total = 0, bad = 0;
    longint exp_hits = 0, exp_misses = 0;
    bit     p_clrv, p_inst, p_rst, p_dec;

    task automatic chk(input string n, input longint got, input longint want);
        total++;
        if (got != want) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", n, got, want);
        end
    endtask

    function automatic longint sat3(input longint v);
        return v > 3 ? 3 : v;
    endfunction

    // Datapath/L2 model: apply last cycle's controls, then offer a word with random L2 latency.
    task automatic edge_begin(input bit hold);
        @(negedge clk);
        if (p_clrv) lstate = L_CLEAN;
        if (p_inst) lstate = L_HIT;
        if (p_rst) cnt = WPL - 1;
        else if (p_dec) cnt = cnt - 1;
        l2_req_fulfilled = !hold && l2_req_valid && $urandom_range(0, 2) != 0;
    endtask

    task automatic settle();
        #1;
        p_clrv = clr_valid;
        p_inst = install;
        p_rst  = rst_cnt;
        p_dec  = dec_cnt;
    endtask

    task automatic idle_cycle();
        edge_begin(1'b0);
        req_valid = 1'b0;
        settle();
    endtask

    task automatic do_req(input int st, input bit is_store, input bit stall);
        int  cyc = 0, loads = 0, stalls = 0;
        bit  done = 0, first = 1, hold;
        exp_t e;
        e.stores   = st == L_DIRTY ? WPL : 0;
        e.loads    = st == L_HIT ? 0 : WPL;
        e.installs = st == L_HIT ? 0 : 1;
        e.hits_before = exp_hits;
        if (st == L_HIT) exp_hits++;
        else exp_misses++;
        e.misses_after = exp_misses;
        q.push_back(e);
        while (!done && cyc < 400) begin
            hold = stall && loads == 3 && stalls < 20;
            edge_begin(hold);
            if (first) begin
                lstate = st;
                req_valid = 1'b1;
                req_type = is_store ? STORE : LOAD;
                first = 0;
            end
            settle();
            if (hold) begin
                stalls++;
                chk("stall_l2_valid", l2_req_valid, 1);
                chk("stall_load_mode", load_mode, 1);
                chk("stall_decrement", dec_cnt, 0);
            end
            if (l2_req_valid && l2_req_fulfilled && l2_req_op == LOAD) loads++;
            done = req_fulfilled;
            cyc++;
        end
        if (!done) chk("req_timeout", 0, 1);
    endtask

    initial begin : monitor
        int m_st = 0, m_ld = 0, m_in = 0;
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (!reset) begin
                m_st = 0; m_ld = 0; m_in = 0;
            end else begin
                if (l2_req_valid && l2_req_fulfilled) begin
                    if (l2_req_op == STORE) m_st++;
                    else m_ld++;
                end
                if (install) m_in++;
                if (req_fulfilled) begin
                    if (q.size() == 0) chk("unexpected_fulfil", 1, 0);
                    else begin
                        e = q.pop_front();
                        chk("store_words", m_st, e.stores);
                        chk("load_words", m_ld, e.loads);
                        chk("install_cycles", m_in, e.installs);
                        chk("hit_count", hit_count, e.hits_before);
                        chk("miss_count", miss_count, e.misses_after);
                        chk("sat_hit_count", s_hit_count, sat3(e.hits_before));
                        chk("sat_miss_count", s_miss_count, sat3(e.misses_after));
                    end
                    m_st = 0; m_ld = 0; m_in = 0;
                end
            end
        end
    end

    initial begin
        int loads;
        reset = 1'b0; req_valid = 1'b1; req_type = LOAD; l2_req_fulfilled = 1'b0; lstate = L_HIT;
        repeat (2) @(negedge clk);
        #1;
        chk("reset_fulfilled", req_fulfilled, 0);
        chk("reset_l2_valid", l2_req_valid, 0);
        chk("reset_l2_op", int'(l2_req_op), int'(LOAD));
        chk("reset_counts", hit_count + miss_count, 0);
        @(negedge clk);
        req_valid = 1'b0;
        reset = 1'b1;
        #1;
        settle();
        do_req(L_HIT, 1'b0, 1'b0);
        idle_cycle();
        chk("first_hit_count", hit_count, 1);
        chk("hit_no_l2", l2_req_valid, 0);
        do_req(L_CLEAN, 1'b0, 1'b1);
        do_req(L_DIRTY, 1'b1, 1'b0);
        repeat (40) begin
            do_req($urandom_range(0, 2), 1'($urandom_range(0, 1)), 1'b0);
            repeat ($urandom_range(0, 2)) idle_cycle();
        end
        idle_cycle();
        chk("random_hits_total", hit_count, exp_hits);
        chk("random_misses_total", miss_count, exp_misses);
        // Reset abandoned three words into a fill.
        loads = 0;
        for (int i = 0; i < 400 && loads < 3; i++) begin
            edge_begin(1'b0);
            lstate = L_CLEAN;
            req_valid = 1'b1;
            settle();
            if (l2_req_valid && l2_req_fulfilled && l2_req_op == LOAD) loads++;
        end
        chk("fill_reached_3_words", loads, 3);
        @(negedge clk);
        reset = 1'b0;
        l2_req_fulfilled = 1'b0;
        #1;
        chk("midfill_reset_l2_valid", l2_req_valid, 0);
        chk("midfill_reset_load_mode", load_mode, 0);
        chk("midfill_reset_decrement", dec_cnt, 0);
        chk("midfill_reset_l2_op", int'(l2_req_op), int'(LOAD));
        chk("midfill_reset_counts", hit_count + miss_count, 0);
        q.delete();
        exp_hits = 0; exp_misses = 0;
        p_clrv = 0; p_inst = 0; p_rst = 0; p_dec = 0;
        req_valid = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        #1;
        idle_cycle();
        chk("post_reset_idle", l2_req_valid | load_mode, 0);
        do_req(L_CLEAN, 1'b0, 1'b0);
        repeat (4) do_req(L_HIT, 1'b0, 1'b0);
        idle_cycle();
        chk("final_hit_count", hit_count, 4);
        chk("final_miss_count", miss_count, 1);
        chk("saturated_hit_count", s_hit_count, 3);
        chk("queue_drained", q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/dcache_controller.md
DCACHE_CONTROLLER -- requirements
Module: dcache_controller

Interface
REQ-001 SHALL have parameter PERF_CNT_WIDTH, default 32, width of the saturating hit/miss counters.
REQ-002 SHALL have parameter WORDS_PER_LINE, default 8, words transferred per L2 burst (informational; the datapath counter sets burst length).
REQ-003 SHALL have port clk  input  1  sole clock; all state changes on its rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port req_valid  input  1  pipeline request present; request fields held stable until req_fulfilled.
REQ-006 SHALL have port req_type  input  memory_operation_e  LOAD or STORE.
REQ-007 SHALL have port req_fulfilled  output  1  single-cycle pulse: request completed this cycle.
REQ-008 SHALL have ports hit, clean_miss, dirty_miss, counter_done  input  1 each  datapath status.
REQ-009 SHALL have ports flush_mode, load_mode, clear_selected_dirty_bit, clear_selected_valid_bit, finish_new_line_install, set_new_l2_block_address, reset_counter, decrement_counter  output  1 each  datapath controls.
REQ-010 SHALL have port l2_req_valid  output  1  word transfer requested from L2.
REQ-011 SHALL have port l2_req_op  output  memory_operation_e  STORE during writeback, LOAD during fill.
REQ-012 SHALL have port l2_req_fulfilled  input  1  L2 completed the current word this cycle.
REQ-013 SHALL have ports hit_count, miss_count  output  PERF_CNT_WIDTH each  saturating performance counters.

Function
REQ-014 SHALL implement states IDLE, WRITEBACK, FILL, INSTALL.
REQ-015 IDLE: if req_valid and hit, SHALL assert req_fulfilled in the same cycle and remain in IDLE (a store is written by the datapath that cycle).
REQ-016 IDLE: if req_valid and dirty_miss, SHALL assert set_new_l2_block_address and reset_counter, next state WRITEBACK.
REQ-017 IDLE: if req_valid and clean_miss, SHALL assert set_new_l2_block_address and reset_counter, next state FILL.
REQ-018 WRITEBACK: SHALL assert flush_mode, l2_req_valid, and l2_req_op=STORE; on l2_req_fulfilled, SHALL assert decrement_counter.
REQ-019 WRITEBACK: on l2_req_fulfilled with counter_done, SHALL assert clear_selected_dirty_bit and clear_selected_valid_bit instead of decrement_counter, next state IDLE; the request is re-evaluated there as a clean miss.
REQ-020 FILL: SHALL assert load_mode, l2_req_valid, and l2_req_op=LOAD; on l2_req_fulfilled, SHALL assert decrement_counter; with counter_done as well, next state INSTALL.
REQ-021 INSTALL: SHALL assert finish_new_line_install and clear_selected_dirty_bit for exactly one cycle, next state IDLE; the retried request then hits.
REQ-022 Without l2_req_fulfilled, WRITEBACK/FILL SHALL hold state and keep l2_req_valid asserted indefinitely (no timeout).
REQ-023 req_valid deasserting mid-miss SHALL NOT abort WRITEBACK/FILL/INSTALL; the line completes, and no req_fulfilled is issued unless req_valid is high in IDLE.
REQ-024 All control outputs SHALL be 0 in any state or condition not listed above; IDLE with req_valid=0 asserts nothing.
REQ-025 A missed flag SHALL set on IDLE→WRITEBACK or IDLE→FILL and clear on req_fulfilled.
REQ-026 miss_count SHALL increment on IDLE→WRITEBACK/FILL only when missed=0; the post-writeback clean-miss retry is not counted twice.
REQ-027 hit_count SHALL increment on req_fulfilled only when missed=0.
REQ-028 Both counters SHALL saturate at all-ones and never wrap.

Reset
REQ-029 Assertion (reset=0) SHALL immediately force state IDLE, missed=0, and hit_count=miss_count=0; all outputs then read 0 (l2_req_op=LOAD).
REQ-030 Reset mid-WRITEBACK/FILL SHALL abandon the burst; no datapath control is asserted after assertion.

Structure
REQ-031 The state enum type SHALL live in xentry_pkg; memory_operation_e SHALL be reused from xentry_pkg.
REQ-032 The saturating counter SHALL be a sub-module, sat_counter (parameter WIDTH; inputs clk, reset, inc; output count), instantiated twice.

Verification
REQ-033 Load hit: req_valid=1, LOAD, hit=1 -> req_fulfilled=1 same cycle, hit_count 0→1, no L2 activity.
REQ-034 Clean miss: clean_miss=1; datapath counter_done after 8 fulfilled words -> 8 l2_req_fulfilled cycles with load_mode=1, one INSTALL cycle, then hit fulfils; miss_count=1, hit_count=0.
REQ-035 Dirty miss: dirty_miss=1 -> 8 STORE words with flush_mode=1, clears on the last word, IDLE retry then 8-word FILL, then INSTALL and fulfil; miss_count=1.
REQ-036 L2 stall: hold l2_req_fulfilled=0 for 20 cycles mid-FILL -> state and l2_req_valid held, decrement_counter=0 throughout.
REQ-037 Reset in FILL after 3 words -> all outputs 0 immediately; IDLE on the next clock; counters 0.
REQ-038 Saturation: preload hit_count to all-ones via PERF_CNT_WIDTH=2 and 4 hits -> hit_count stays 3.
